// File: rtl/sq_gen_if.sv
// Operand/result bundle for sq_gen: start request and root in, square and status out.
interface sq_gen_if #(
  parameter int W = 8
);
  logic           go;
  logic [W-1:0]   in;
  logic [2*W-1:0] sq;
  logic           over;
  logic           busy;

  modport master (output go, in, input sq, over, busy);
  modport slave  (input go, in, output sq, over, busy);
endinterface

// File: rtl/sq_gen.sv
// Multiplier-free squarer: in*in built as the sum of the first `in` odd numbers.
// Optional feature macro SQ_RESTART_EN: a go during accumulation restarts with the new operand.
module sq_gen #(
  parameter int W = 8
) (
  input logic     clk,
  input logic     rst_n,
  sq_gen_if.slave io_bus
);
  localparam int W2 = 2 * W;
  localparam logic [W2-1:0] C_ZERO2    = W2'(0);
  localparam logic [W2-1:0] C_ODD_INIT = W2'(1);
  localparam logic [W2-1:0] C_ODD_STEP = W2'(2);
  localparam logic [W-1:0]  C_ZERO1    = W'(0);
  localparam logic [W-1:0]  C_ONE1     = W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_cnt;
  logic [W2-1:0] r_sum;
  logic [W2-1:0] r_odd;
  logic [W2-1:0] r_sq;
  logic          r_over;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [W-1:0]  w_cnt_nxt;
  logic [W2-1:0] w_sum_nxt;
  logic [W2-1:0] w_odd_nxt;
  logic [W2-1:0] w_sq_nxt;
  logic          w_over_nxt;
  logic          w_busy_nxt;
  logic          w_load;

  // State register and datapath registers; reset abandons any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= C_ZERO1;
      r_sum   <= C_ZERO2;
      r_odd   <= C_ODD_INIT;
      r_sq    <= C_ZERO2;
      r_over  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
      r_odd   <= w_odd_nxt;
      r_sq    <= w_sq_nxt;
      r_over  <= w_over_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and datapath decode; every register holds unless a branch below moves it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_odd_nxt   = r_odd;
    w_sq_nxt    = r_sq;
    w_over_nxt  = r_over;
    w_busy_nxt  = r_busy;
    w_load      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: w_load = io_bus.go;
`ifdef SQ_RESTART_EN
      ST_ACC:           w_load = io_bus.go;
`else
      ST_ACC:           w_load = 1'b0;
`endif
      default:          w_load = 1'b0;
    endcase

    if (w_load) begin
      w_state_nxt = ST_ACC;
      w_cnt_nxt   = io_bus.in;
      w_sum_nxt   = C_ZERO2;
      w_odd_nxt   = C_ODD_INIT;
      w_over_nxt  = 1'b0;
      w_busy_nxt  = 1'b1;
    end else if (r_state == ST_ACC) begin
      if (r_cnt != C_ZERO1) begin
        w_sum_nxt = r_sum + r_odd;
        w_odd_nxt = r_odd + C_ODD_STEP;
        w_cnt_nxt = r_cnt - C_ONE1;
      end else begin
        w_sq_nxt    = r_sum;
        w_over_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_DONE;
      end
    end else if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
      w_state_nxt = r_state;
    end else begin
      // Unreachable encoding: fall back to a quiet idle.
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
    end
  end

  assign io_bus.sq   = r_sq;
  assign io_bus.over = r_over;
  assign io_bus.busy = r_busy;

endmodule
